mic_delay_sched: RTL

- Per-frame scheduler for the microphone delay-line RAM.
- On each new I2S frame it writes the NCHAN latest mic samples into a shared single-port synchronous RAM, one circular buffer per channel.
- It then reads back one delayed sample per channel using per-channel programmable delays, and streams them tagged with channel number to the downstream gain/sum stage.
- It owns the RAM port exclusively and sequences write and read phases so they never collide.

---
 rtl/mic_delay_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mic_delay_sched.sv
// Per-frame microphone delay-line scheduler: writes each new frame into per-channel
// circular buffers in a shared single-port RAM, then streams one delayed sample per channel.
module mic_delay_sched #(
    parameter int NCHAN = 6,
    parameter int DW    = 16,
    parameter int PW    = 6,
    parameter int CW    = 3
) (
    input  logic                ck,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NCHAN*DW-1:0] mics,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [PW-1:0]       cfg_delay,
    output logic [CW+PW-1:0]    ram_addr,
    output logic [DW-1:0]       ram_wdata,
    output logic                ram_we,
    input  logic [DW-1:0]       ram_rdata,
    output logic [DW-1:0]       out_data,
    output logic [CW-1:0]       out_chan,
    output logic                out_valid,
    output logic                done,
    output logic                busy,
    output logic                primed,
    output logic                overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_CH   = CW'(NCHAN - 1);
    localparam logic [CW-1:0] LAST_DRN  = CW'(1);
    localparam logic [CW:0]   NCHAN_LIM = (CW+1)'(NCHAN);
    localparam logic [PW-1:0] PTR_MAX   = {PW{1'b1}};

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   delay_q  [NCHAN];
    logic [PW-1:0]   sh_delay [NCHAN];
    logic [DW-1:0]   sh_mic   [NCHAN];
    logic [CW+PW-1:0] addr_hold;
    logic [DW-1:0]   wdata_hold;
    logic            rd_v1;
    logic [CW-1:0]   rd_c1;
    logic            accept;
    logic            frame_end;

    assign accept    = (state == IDLE) && start;
    assign frame_end = (state == DRAIN) && (cnt == LAST_DRN);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (cnt == LAST_CH) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            READ: begin
                if (cnt == LAST_CH) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Circular read pointer; modulo 2^PW falls out of the PW-bit subtraction.
    assign rd_ptr = wr_ptr - sh_delay[cnt];

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        case (state)
            WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = {cnt, wr_ptr};
                ram_wdata = sh_mic[cnt];
            end
            READ: begin
                ram_addr = {cnt, rd_ptr};
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= ram_addr;
            wdata_hold <= ram_wdata;
        end
    end

    // NOTE: the delay and shadow arrays are small register files, so they are reset like any other state.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                delay_q[c] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_chan} < NCHAN_LIM)) begin
            delay_q[cfg_chan] <= cfg_delay;
        end
    end

    // Shadows freeze the frame's samples and delays so mid-frame config writes wait a frame.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                sh_delay[c] <= '0;
                sh_mic[c]   <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < NCHAN; c++) begin
                sh_delay[c] <= delay_q[c];
                sh_mic[c]   <= mics[c*DW +: DW];
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            primed  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (frame_end) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (wr_ptr == PTR_MAX) begin
                    primed <= 1'b1;
                end
            end
            if (start && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Two-stage read return: RAM latency, then the output register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1     <= 1'b0;
            rd_c1     <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            rd_v1     <= (state == READ);
            rd_c1     <= cnt;
            out_valid <= rd_v1;
            out_chan  <= rd_c1;
            done      <= rd_v1 && (rd_c1 == LAST_CH);
            if (rd_v1) begin
                out_data <= ram_rdata;
            end
        end
    end

endmodule
